// File: rtl/rvh_l1d_pkg.sv
// Shared L1D types and sizes used by the refill buffer and its neighbours.
// Holds the L2 R-channel beat format, the MSHR entry layout and the refill FSM state.
package rvh_l1d_pkg;

  localparam int unsigned N_BANK         = 4;
  localparam int unsigned N_MSHR         = 8;
  localparam int unsigned N_MSHR_W       = $clog2(N_MSHR);
  localparam int unsigned BURST_SIZE     = 4;
  localparam int unsigned MEM_DATA_WIDTH = 64;
  localparam int unsigned PADDR_WIDTH    = 40;
  localparam int unsigned LSU_TAG_WIDTH  = 8;
  localparam int unsigned BEAT_CNT_W     = $clog2(BURST_SIZE);
  localparam int unsigned LINE_WIDTH     = BURST_SIZE * MEM_DATA_WIDTH;

  typedef struct packed {
    logic [N_MSHR_W-1:0] tid;
  } cache_mem_if_rid_t;

  typedef struct packed {
    cache_mem_if_rid_t         rid;
    logic [MEM_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
  } cache_mem_if_r_t;

  typedef struct packed {
    logic                     valid;
    logic                     is_store;
    logic [PADDR_WIDTH-1:0]   paddr;
    logic [LSU_TAG_WIDTH-1:0] lsu_tag;
  } mshr_t;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StRefill,
    StDealloc
  } rvh_l1d_refill_state_e;

  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_LAST = BEAT_CNT_W'(BURST_SIZE - 1);

  // Extra beats past the end of a burst keep landing in the last slot.
  function automatic logic [BEAT_CNT_W-1:0] beat_cnt_inc(input logic [BEAT_CNT_W-1:0] cnt);
    return (cnt == BEAT_CNT_LAST) ? cnt : cnt + BEAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/std_dffr.sv
// Plain D flip-flop with synchronous active-low reset to zero.
module std_dffr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/std_dffre.sv
// D flip-flop with load enable and synchronous active-low reset to zero.
// Tie rstn high for storage that needs no reset value.
module std_dffre #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rvh_l1d_refill_buf.sv
// L1D refill buffer: gathers one L2 burst into a line, hands it to the cache pipeline,
// then frees the owning MSHR. Define RVH_L1D_REFILL_ERR_CHECK_EN to add refill_err_o.
module rvh_l1d_refill_buf
  import rvh_l1d_pkg::*;
#(
  parameter int unsigned BANK_ID = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 l2_resp_if_rvalid,
  output logic                                 l2_resp_if_rready,
  input  cache_mem_if_r_t                      l2_resp_if_r,
  input  mshr_t                                mshr_bank_i [N_MSHR],
  input  logic [N_MSHR-1:0]                    mshr_bank_no_resp_i,
  output logic                                 refill_valid_o,
  input  logic                                 refill_ready_i,
  output logic [N_MSHR_W-1:0]                  refill_mshr_id_o,
  output mshr_t                                refill_mshr_o,
  output logic [BURST_SIZE*MEM_DATA_WIDTH-1:0] refill_line_o,
  output logic                                 refill_no_resp_o,
`ifdef RVH_L1D_REFILL_ERR_CHECK_EN
  output logic                                 refill_err_o,
`endif
  output logic                                 mlfb_mshr_dealloc_valid_o,
  output logic [N_MSHR_W-1:0]                  mlfb_mshr_dealloc_idx_o,
  input  logic                                 mlfb_mshr_dealloc_ready_i
);

  rvh_l1d_refill_state_e   state_q, state_d;
  logic [1:0]              state_q_raw;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [N_MSHR_W-1:0]     id_q;
  logic                    id_en;
  logic                    no_resp_q, no_resp_d;
  logic                    beat_fire, last_fire, refill_fire, dealloc_fire;
  logic [N_MSHR_W-1:0]     cur_id;
  logic [MEM_DATA_WIDTH-1:0] line_q [BURST_SIZE];

  logic unused_bank;
  assign unused_bank = ^BANK_ID;

  assign beat_fire    = l2_resp_if_rvalid & l2_resp_if_rready;
  assign last_fire    = beat_fire & l2_resp_if_r.rlast;
  assign refill_fire  = refill_valid_o & refill_ready_i;
  assign dealloc_fire = mlfb_mshr_dealloc_valid_o & mlfb_mshr_dealloc_ready_i;

  // The id register only loads on the first beat, so a single-beat burst must use the live tid.
  assign cur_id = (state_q == StIdle) ? l2_resp_if_r.rid.tid : id_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  std_dffr #(
    .WIDTH(2)
  ) u_state_dff (
    .clk (clk),
    .rstn(rst),
    .d   (state_d),
    .q   (state_q_raw)
  );

  assign state_q = rvh_l1d_refill_state_e'(state_q_raw);

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (beat_fire) begin
          state_d = l2_resp_if_r.rlast ? StRefill : StCollect;
        end
      end
      StCollect: begin
        if (last_fire) begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (refill_ready_i) begin
          state_d = StDealloc;
        end
      end
      StDealloc: begin
        if (mlfb_mshr_dealloc_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    l2_resp_if_rready         = 1'b0;
    refill_valid_o            = 1'b0;
    mlfb_mshr_dealloc_valid_o = 1'b0;
    unique case (state_q)
      StIdle, StCollect: l2_resp_if_rready         = 1'b1;
      StRefill:          refill_valid_o            = 1'b1;
      StDealloc:         mlfb_mshr_dealloc_valid_o = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat counter and captured MSHR id
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat_fire) begin
      beat_cnt_d = beat_cnt_inc(beat_cnt_q);
    end else if (refill_fire) begin
      beat_cnt_d = '0;
    end
  end

  std_dffr #(
    .WIDTH(BEAT_CNT_W)
  ) u_beat_cnt_dff (
    .clk (clk),
    .rstn(rst),
    .d   (beat_cnt_d),
    .q   (beat_cnt_q)
  );

  assign id_en = beat_fire & (state_q == StIdle);

  std_dffre #(
    .WIDTH(N_MSHR_W)
  ) u_id_dff (
    .clk (clk),
    .rstn(rst),
    .en  (id_en),
    .d   (l2_resp_if_r.rid.tid),
    .q   (id_q)
  );

  // ---------------------------------------------------------------------------
  // no_resp: snapshot on the last beat, then accumulate any later ROB flush
  // ---------------------------------------------------------------------------
  always_comb begin
    no_resp_d = no_resp_q;
    if (last_fire) begin
      no_resp_d = mshr_bank_no_resp_i[cur_id];
    end else if (refill_fire) begin
      no_resp_d = 1'b0;
    end else if (state_q == StRefill) begin
      no_resp_d = no_resp_q | mshr_bank_no_resp_i[id_q];
    end
  end

  std_dffr #(
    .WIDTH(1)
  ) u_no_resp_dff (
    .clk (clk),
    .rstn(rst),
    .d   (no_resp_d),
    .q   (no_resp_q)
  );

  // ---------------------------------------------------------------------------
  // Line storage: one slot per beat, not reset
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < BURST_SIZE; i++) begin : g_slot
    logic slot_en;
    assign slot_en = beat_fire & (beat_cnt_q == BEAT_CNT_W'(i));

    std_dffre #(
      .WIDTH(MEM_DATA_WIDTH)
    ) u_slot_dff (
      .clk (clk),
      .rstn(1'b1),
      .en  (slot_en),
      .d   (l2_resp_if_r.rdata),
      .q   (line_q[i])
    );

    assign refill_line_o[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = line_q[i];
  end

  // ---------------------------------------------------------------------------
  // Refill / dealloc payload
  // ---------------------------------------------------------------------------
  assign refill_mshr_id_o        = id_q;
  assign refill_mshr_o           = mshr_bank_i[id_q];
  // A flush landing in the handshake cycle itself must still suppress the LSU response.
  assign refill_no_resp_o        = (state_q == StRefill) &
                                   (no_resp_q | mshr_bank_no_resp_i[id_q]);
  assign mlfb_mshr_dealloc_idx_o = id_q;

`ifdef RVH_L1D_REFILL_ERR_CHECK_EN
  logic err_q, err_d;
  logic beat_err;

  assign beat_err = (l2_resp_if_r.rresp != 2'b00) |
                    (l2_resp_if_r.rlast & (beat_cnt_q != BEAT_CNT_LAST));

  always_comb begin
    err_d = err_q;
    if (beat_fire) begin
      err_d = err_q | beat_err;
    end else if (dealloc_fire) begin
      err_d = 1'b0;
    end
  end

  std_dffr #(
    .WIDTH(1)
  ) u_err_dff (
    .clk (clk),
    .rstn(rst),
    .d   (err_d),
    .q   (err_q)
  );

  assign refill_err_o = err_q;
`else
  logic unused_err;
  assign unused_err = ^{l2_resp_if_r.rresp, dealloc_fire};
`endif

endmodule
